// File: rtl/control_unit_seq.sv
// control_unit_seq: multi-cycle CPU control FSM (IDLE/EXEC/MEM/WB/TRAP) with registered outputs.
// Define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes; otherwise they execute as a NOP.
module control_unit_seq #(
    parameter int unsigned OPCODE_W = 8,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                busywait,
    output logic                writeenable,
    output logic                alusrc,
    output logic                nemux,
    output logic                read,
    output logic                write,
    output logic                writesrc,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          branch,
    output logic                pc_stall,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic                illegal
);

    typedef enum logic [2:0] {StIdle, StExec, StMem, StWb, StTrap} state_e;

    typedef struct packed {
        logic       we;
        logic       alusrc;
        logic       nemux;
        logic [2:0] aluop;
        logic [1:0] branch;
        logic       load;
        logic       store;
    } dec_t;

    typedef struct packed {
        logic               we;
        logic               alusrc;
        logic               nemux;
        logic               read;
        logic               write;
        logic               writesrc;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         branch;
        logic               pc_stall;
    } out_t;

    // Illegal opcodes (upper bits set, 0x0B, 0x12+) fall through to an all-zero decode.
    function automatic dec_t decode(input logic [OPCODE_W-1:0] op);
        dec_t d;
        d = '0;
        case (16'(op))
            16'h00: begin d.we = 1'b1; d.alusrc = 1'b1; d.aluop = 3'b001; end
            16'h01: begin d.we = 1'b1; d.alusrc = 1'b1; d.aluop = 3'b001; d.nemux = 1'b1; end
            16'h02: begin d.we = 1'b1; d.alusrc = 1'b1; d.aluop = 3'b010; end
            16'h03: begin d.we = 1'b1; d.alusrc = 1'b1; d.aluop = 3'b011; end
            16'h04: begin d.we = 1'b1; d.alusrc = 1'b1; d.aluop = 3'b000; end
            16'h05: begin d.we = 1'b1; d.aluop = 3'b000; end
            16'h06: d.branch = 2'b01;
            16'h07: begin d.aluop = 3'b001; d.nemux = 1'b1; d.branch = 2'b10; end
            16'h08: begin d.aluop = 3'b001; d.nemux = 1'b1; d.branch = 2'b11; end
            16'h09: begin d.we = 1'b1; d.alusrc = 1'b1; d.aluop = 3'b100; end
            16'h0A: begin d.we = 1'b1; d.aluop = 3'b101; end
            16'h0C: begin d.we = 1'b1; d.aluop = 3'b110; end
            16'h0D: begin d.we = 1'b1; d.aluop = 3'b111; end
            16'h0E: begin d.load = 1'b1; d.alusrc = 1'b1; end
            16'h0F: d.load = 1'b1;
            16'h10: begin d.store = 1'b1; d.alusrc = 1'b1; end
            16'h11: d.store = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

    state_e           state_q, state_d;
    dec_t             dec_q, dec_d;
    out_t             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             trap_in;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;

    assign trap_in = (16'(opcode) == 16'h0B) || (16'(opcode) > 16'h11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else if (state_d == StTrap) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign trap_in = 1'b0;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            dec_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: accept = instr_valid;
            StExec: begin
                if (dec_q.load || dec_q.store) begin
                    state_d = StMem;
                end else begin
                    accept  = instr_valid;
                    state_d = StIdle;
                end
            end
            StMem:   if (!busywait) state_d = dec_q.load ? StWb : StIdle;
            StWb:    state_d = StIdle;
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            dec_d   = decode(opcode);
            state_d = trap_in ? StTrap : StExec;
        end
    end

    // Outputs are computed for the state being entered so they appear registered.
    always_comb begin
        out_d = '0;
        case (state_d)
            StExec: begin
                out_d.we     = dec_d.we;
                out_d.alusrc = dec_d.alusrc;
                out_d.nemux  = dec_d.nemux;
                out_d.aluop  = ALUOP_W'(dec_d.aluop);
                out_d.branch = dec_d.branch;
            end
            StMem: begin
                out_d.read     = dec_d.load;
                out_d.write    = dec_d.store;
                out_d.pc_stall = 1'b1;
                out_d.alusrc   = dec_d.alusrc;
                out_d.aluop    = ALUOP_W'(dec_d.aluop);
            end
            StWb: begin
                out_d.we       = 1'b1;
                out_d.writesrc = 1'b1;
            end
            default: out_d = '0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StMem && busywait && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign writeenable  = out_q.we;
    assign alusrc       = out_q.alusrc;
    assign nemux        = out_q.nemux;
    assign read         = out_q.read;
    assign write        = out_q.write;
    assign writesrc     = out_q.writesrc;
    assign aluop        = out_q.aluop;
    assign branch       = out_q.branch;
    assign pc_stall     = out_q.pc_stall;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: per-cycle expected outputs queued by the driver, checked by a monitor.
module tb_control_unit_seq;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    typedef struct packed {
        logic             we, alusrc, nemux, rd, wr, wsrc;
        logic [2:0]       aluop;
        logic [1:0]       br;
        logic             stall;
        logic [CNT_W-1:0] cnt;
        logic             ill;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       opcode;
    logic             instr_valid, busywait;
    logic             writeenable, alusrc, nemux, read, write, writesrc, pc_stall, illegal;
    logic [2:0]       aluop;
    logic [1:0]       branch;
    logic [CNT_W-1:0] stall_cycles;
    vec_t             got;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt  = 0;
    logic m_ill  = 1'b0;

    control_unit_seq #(.OPCODE_W(8), .ALUOP_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .instr_valid(instr_valid),
        .busywait(busywait), .writeenable(writeenable), .alusrc(alusrc), .nemux(nemux),
        .read(read), .write(write), .writesrc(writesrc), .aluop(aluop), .branch(branch),
        .pc_stall(pc_stall), .stall_cycles(stall_cycles), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign got = {writeenable, alusrc, nemux, read, write, writesrc, aluop, branch, pc_stall,
                  stall_cycles, illegal};

    task automatic check_vec(input string name, input vec_t g, input vec_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, g, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) check_vec("cycle", got, q.pop_front());
    end

    function automatic bit is_illegal(input logic [7:0] op);
        return (op == 8'h0B) || (op > 8'h11);
    endfunction

    function automatic vec_t zero_vec();
        vec_t v;
        v     = '0;
        v.cnt = CNT_W'(m_cnt);
        v.ill = m_ill;
        return v;
    endfunction

    // Expected EXEC-cycle controls straight from the opcode table.
    function automatic vec_t exec_vec(input logic [7:0] op);
        vec_t v;
        v = zero_vec();
        case (op)
            8'h00: begin v.we = 1; v.alusrc = 1; v.aluop = 3'b001; end
            8'h01: begin v.we = 1; v.alusrc = 1; v.aluop = 3'b001; v.nemux = 1; end
            8'h02: begin v.we = 1; v.alusrc = 1; v.aluop = 3'b010; end
            8'h03: begin v.we = 1; v.alusrc = 1; v.aluop = 3'b011; end
            8'h04: begin v.we = 1; v.alusrc = 1; end
            8'h05: v.we = 1;
            8'h06: v.br = 2'b01;
            8'h07: begin v.aluop = 3'b001; v.nemux = 1; v.br = 2'b10; end
            8'h08: begin v.aluop = 3'b001; v.nemux = 1; v.br = 2'b11; end
            8'h09: begin v.we = 1; v.alusrc = 1; v.aluop = 3'b100; end
            8'h0A: begin v.we = 1; v.aluop = 3'b101; end
            8'h0C: begin v.we = 1; v.aluop = 3'b110; end
            8'h0D: begin v.we = 1; v.aluop = 3'b111; end
            8'h0E, 8'h10: v.alusrc = 1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic int mem_kind(input logic [7:0] op);
        if (op == 8'h0E || op == 8'h0F) return 1;
        if (op == 8'h10 || op == 8'h11) return 2;
        return 0;
    endfunction

    function automatic logic [7:0] pick_op();
        logic [7:0] op;
        if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
        else op = 8'($urandom_range(0, 31));
        if (TrapEn) while (is_illegal(op)) op = 8'($urandom_range(0, 17));
        return op;
    endfunction

    task automatic cycle(input logic iv, input logic [7:0] op, input logic bw, input vec_t e);
        instr_valid = iv;
        opcode      = op;
        busywait    = bw;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), zero_vec());
    endtask

    // One instruction from its accepting edge until the FSM is free to accept again.
    task automatic issue(input logic [7:0] op, input int nbusy);
        vec_t v;
        int   k;
        k = mem_kind(op);
        if (TrapEn && is_illegal(op)) begin
            m_ill = 1'b1;
            cycle(1'b1, op, 1'($urandom_range(0, 1)), zero_vec());
            return;
        end
        v = exec_vec(op);
        cycle(1'b1, op, 1'($urandom_range(0, 1)), v);
        if (k == 0) return;
        v.rd    = (k == 1);
        v.wr    = (k == 2);
        v.stall = 1'b1;
        cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), v);
        for (int i = 0; i < nbusy; i++) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            v.cnt = CNT_W'(m_cnt);
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1, v);
        end
        if (k == 1) begin
            v      = zero_vec();
            v.we   = 1'b1;
            v.wsrc = 1'b1;
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, v);
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), zero_vec());
        end else begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, zero_vec());
        end
    endtask

    task automatic assert_reset(input string name);
        reset = 1'b0;
        q.delete();
        m_cnt = 0;
        m_ill = 1'b0;
        #1;
        check_vec(name, got, zero_vec());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1);
    end

    initial begin
        vec_t v;
        instr_valid = 1'b0;
        opcode      = 8'h00;
        busywait    = 1'b0;
        assert_reset("reset_async");
        instr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_vec("reset_held", got, zero_vec());
        @(negedge clk);
        #1 reset = 1'b1;

        issue(8'h01, 0);
        idle(1);
        issue(8'h0F, 3);
        issue(8'h10, 0);
        issue(8'h00, 0);
        issue(8'h07, 0);
        issue(8'h06, 0);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            issue(pick_op(), $urandom_range(0, 4));
            idle($urandom_range(0, 2));
        end

        // Reset while a load is stalled in MEM.
        v = exec_vec(8'h0E);
        cycle(1'b1, 8'h0E, 1'b0, v);
        v.rd    = 1'b1;
        v.stall = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, v);
        if (m_cnt < CNT_MAX) m_cnt++;
        v.cnt = CNT_W'(m_cnt);
        cycle(1'b0, 8'h00, 1'b1, v);
        @(negedge clk);
        #1 assert_reset("reset_mid_mem");
        #2 reset = 1'b1;
        issue(8'h00, 0);
        idle(1);

`ifdef ILLEGAL_OP_TRAP_EN
        issue(8'h0B, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i), 1'b1, zero_vec());
        @(negedge clk);
        #1 assert_reset("reset_clears_trap");
        #2 reset = 1'b1;
        issue(8'h02, 0);
`else
        issue(8'h0B, 0);
        issue(8'h00, 0);
        issue(8'h25, 0);
        issue(8'h03, 0);
`endif
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit_seq.md
CONTROL_UNIT_SEQ -- requirements
Module: control_unit_seq

Interface
REQ-001 Parameter OPCODE_W, default 8, SHALL set the opcode width (legal range 5 to 16).
REQ-002 Parameter ALUOP_W, default 3, SHALL set the ALUOP width (minimum 3); encodings SHALL be zero-extended.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RESET  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 OPCODE  in  OPCODE_W  SHALL carry the instruction opcode and SHALL be sampled only when INSTR_VALID=1.
REQ-007 INSTR_VALID  in  1  SHALL indicate that a fetched instruction is available.
REQ-008 BUSYWAIT  in  1  SHALL indicate that data memory is busy.
REQ-009 WRITEENABLE, ALUSRC, NEMUX, READ, WRITE, WRITESRC  out  1 each  SHALL have the meanings of the existing CPU control signals.
REQ-010 ALUOP  out  ALUOP_W  and  BRANCH  out  2  SHALL use the existing ALU and branch encodings.
REQ-011 PC_STALL  out  1  SHALL hold the PC and fetch.
REQ-012 STALL_CYCLES  out  CNT_W  SHALL count memory-wait cycles.
REQ-013 ILLEGAL  out  1  SHALL be a sticky illegal-opcode flag.

Function
REQ-014 States SHALL be IDLE, EXEC, MEM, WB and TRAP; all outputs SHALL be registered.
REQ-015 IDLE: all control outputs SHALL be 0; INSTR_VALID=1 at an edge SHALL latch OPCODE and enter EXEC.
REQ-016 EXEC SHALL last one cycle and drive the decode of the latched opcode:
- 0x00 ADD: ALUOP=001
- 0x01 SUB: ALUOP=001, NEMUX=1
- 0x02 AND: ALUOP=010
- 0x03 OR: ALUOP=011
- 0x04 MOV: ALUOP=000
- 0x05 LOADI: ALUOP=000, ALUSRC=0
- 0x06 J: BRANCH=01
- 0x07 BEQ: ALUOP=001, NEMUX=1, BRANCH=10
- 0x08 BNE: ALUOP=001, NEMUX=1, BRANCH=11
- 0x09 MULT: ALUOP=100
- 0x0A SL: ALUOP=101, ALUSRC=0
- 0x0C SRA: ALUOP=110, ALUSRC=0
- 0x0D ROR: ALUOP=111, ALUSRC=0
- 0x0E LWD, 0x0F LWI, 0x10 SWD, 0x11 SWI: ALUOP=000; ALUSRC=1 for LWD and SWD, 0 for LWI and SWI
- ALU and shift ops: WRITEENABLE=1, ALUSRC=1 unless stated above
- Any signal not listed for an opcode SHALL be 0.
REQ-017 A non-memory op in EXEC SHALL go to EXEC if INSTR_VALID=1 (back-to-back, new opcode latched), else to IDLE.
REQ-018 A memory op in EXEC SHALL go to MEM with WRITEENABLE=0.
REQ-019 MEM SHALL assert READ (loads) or WRITE (stores) and PC_STALL=1, and SHALL hold ALUOP and ALUSRC from EXEC.
REQ-020 MEM SHALL persist for at least one cycle and exit only on an edge where BUSYWAIT=0: loads SHALL go to WB, stores to IDLE.
REQ-021 READ and WRITE SHALL deassert in the cycle after MEM exits, and SHALL never be high simultaneously.
REQ-022 WB SHALL last one cycle with WRITEENABLE=1, WRITESRC=1 and READ=0, then go to IDLE.
REQ-023 STALL_CYCLES SHALL increment on each edge in MEM with BUSYWAIT=1 and SHALL saturate at all-ones (no wrap).
REQ-024 INSTR_VALID SHALL be ignored in MEM, WB and TRAP.
REQ-025 Opcode bits above bit 4 that are nonzero SHALL make the opcode illegal, as SHALL 0x0B and 0x12-0x1F.

Reset
REQ-026 RESET=0 SHALL immediately force state IDLE, all control outputs 0, STALL_CYCLES=0 and ILLEGAL=0, including mid-MEM (READ/WRITE drop without waiting for BUSYWAIT).
REQ-027 The first state change after release SHALL occur at the first rising edge with RESET=1.

Configuration
REQ-028 With ILLEGAL_OP_TRAP_EN defined, an illegal opcode latched into EXEC SHALL set ILLEGAL=1, drive all controls 0 and enter TRAP, which SHALL be left only by reset.
REQ-029 Without ILLEGAL_OP_TRAP_EN, an illegal opcode SHALL execute as a one-cycle NOP (all controls 0), ILLEGAL SHALL be tied 0, and TRAP SHALL be unreachable.

Verification
REQ-030 Reset, then INSTR_VALID=1 with OPCODE=0x01 -> next cycle WRITEENABLE=1, ALUOP=001, NEMUX=1, ALUSRC=1; then IDLE with all controls 0.
REQ-031 OPCODE=0x0F, BUSYWAIT high for 3 cycles -> READ=1 and PC_STALL=1 through MEM, STALL_CYCLES=3, then one WB cycle with WRITEENABLE=1 and WRITESRC=1.
REQ-032 OPCODE=0x10, BUSYWAIT=0 -> exactly one MEM cycle with WRITE=1 and WRITEENABLE=0, then IDLE.
REQ-033 INSTR_VALID held high with OPCODEs 0x00, 0x07, 0x06 -> three consecutive EXEC cycles with BRANCH=00, 10, 01.
REQ-034 RESET=0 asserted mid-MEM with BUSYWAIT=1 -> READ=0 and STALL_CYCLES=0 immediately, without waiting for a clock edge.
REQ-035 OPCODE=0x0B -> with ILLEGAL_OP_TRAP_EN: ILLEGAL=1 and later INSTR_VALID ignored; without it: one NOP cycle, then normal operation.
